dmem_wb_master: RTL and testbench
=================================

Name: dmem_wb_master

Overview:
- Data-memory bus master for the MEM stage of the pipelined RV32I core.
- Turns MEM-stage load/store requests into Wishbone B4 classic single transfers.
- Drives stall_pipl back to the control unit, which holds the pipeline while a transfer is in flight.
- Performs store byte-lane steering and load sign/zero extension by fun3; flags misaligned/illegal accesses and bus errors/timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: max BUS cycles without ack/err before abort; 0 disables the timeout.
- ADDR_W, 32: Wishbone address width. Byte address, passed unmodified.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_read_mem  in  1  MEM-stage load request (mem_to_reg_mem).
- mem_write_mem  in  1  MEM-stage store request.
- fun3_mem  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr_mem  in  32  byte address (ALU result).
- wdata_mem  in  32  store data, unaligned (rs2 value).
- rdata_mem  out  32  extended load data, valid in DONE.
- stall_pipl  out  1  pipeline stall to the control unit.
- misaligned  out  1  one-cycle pulse: misaligned or illegal fun3 access.
- bus_err  out  1  one-cycle pulse: wb_err_i or timeout.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  ADDR_W  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_sel_o  out  4  Wishbone byte selects.
- wb_dat_i  in  32  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.

Behaviour:
- req = mem_read_mem | mem_write_mem. If both are set, the access is a write.
- States and transitions:
  - IDLE: if req, the access is legal and aligned, go to BUS. If req and it is misaligned or illegal, go to DONE.
  - BUS: on ack, err or timeout, go to DONE.
  - DONE: go to IDLE unconditionally.
- stall_pipl (combinational):
  - 1 in IDLE when req.
  - 1 in all of BUS.
  - 0 in DONE, so the pipeline advances exactly once per access.
  - 0 in IDLE when no req.
- Latching on the IDLE→BUS edge: adr, we, sel, steered data and fun3. Wishbone outputs come from these registers, stable for the whole cycle.
- wb_cyc_o = wb_stb_o = 1 throughout BUS and 0 in every other state.
- Store steering and byte selects:
  - SB: byte replicated ×4; sel = 0001 << addr[1:0].
  - SH: half replicated ×2; sel = 0011 (addr[1]=0) or 1100.
  - SW: sel = 1111.
  - Loads: sel per the same rule; wb_dat_o = 0.
- Alignment and legality:
  - Misaligned: size H with addr[0]=1, or size W with addr[1:0]≠0.
  - Illegal: fun3 ∈ {011, 110, 111}, or a store with fun3[2]=1.
  - Either case: no bus cycle, misaligned pulses in the DONE cycle, rdata_mem = 0.
- Load data:
  - On ack, capture wb_dat_i into a register.
  - In DONE, rdata_mem = the lane selected by latched addr[1:0], sign- or zero-extended per fun3.
  - rdata_mem = 0 outside DONE.
- Errors:
  - wb_err_i in BUS: go to DONE, bus_err=1 in DONE, rdata_mem=0.
  - Timeout: 8-bit-or-wider counter cleared on BUS entry, increments each BUS cycle. At count == TIMEOUT_CYCLES−1 without ack/err: drop cyc/stb and go to DONE with bus_err=1. A late ack after abort is ignored.
  - ack and err in the same cycle: err wins.
- Latency with ack in the first BUS cycle: stall for 2 cycles (IDLE, BUS), DONE on the third.
- Back-to-back accesses: a new req seen in IDLE right after DONE starts a fresh transfer. Nothing is pipelined.
- Reset values: state=IDLE; all Wishbone outputs 0; stall_pipl=0, misaligned=0, bus_err=0, rdata_mem=0; counter=0.
- Reset mid-BUS: cyc/stb are 0 after the reset edge; the in-flight access is discarded.

Test Plan:
- LW addr=0x100, ack on the 1st BUS cycle with wb_dat_i=0xDEADBEEF → stall_pipl 1,1,0; rdata_mem=0xDEADBEEF in DONE; wb_sel_o=1111, wb_we_o=0.
- LB addr=0x103, dat=0x80112233 → sel=1000, rdata=0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr=0x102 → 0x00008011.
- SB addr=0x201, wdata=0x000000A5 → wb_dat_o=0xA5A5A5A5, sel=0010, we=1. SH addr=0x202, wdata=0x1234 → dat=0x12341234, sel=1100.
- LW addr=0x101 → no cyc/stb; misaligned pulses for 1 cycle; stall for 1 cycle only.
- Ack withheld, TIMEOUT_CYCLES=4 → cyc drops after 4 BUS cycles; bus_err=1 in DONE; rdata=0. wb_err_i on the 2nd BUS cycle → DONE next cycle with bus_err=1.
- Reset asserted during the 2nd BUS cycle → cyc=stb=0 and stall_pipl=0 the following cycle.

Source files
------------

// File: rtl/dmem_wb_master.sv
// rtl/dmem_wb_master.sv - MEM-stage data-memory Wishbone B4 classic master
// One single transfer per load/store; the pipeline is stalled until the DONE cycle.
module dmem_wb_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic [2:0]        fun3_mem,
  input  logic [31:0]       addr_mem,
  input  logic [31:0]       wdata_mem,
  output logic [31:0]       rdata_mem,
  output logic              stall_pipl,
  output logic              misaligned,
  output logic              bus_err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] adr_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;
  logic [2:0]        fun3_q;
  logic [31:0]       rdat_q;
  logic              mis_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              req;
  logic              illegal;
  logic              unaligned;
  logic              access_bad;
  logic              timeout_hit;
  logic [3:0]        sel_c;
  logic [31:0]       dat_c;
  logic [31:0]       lane;

  assign req = mem_read_mem | mem_write_mem;

  // Decode of the incoming request: legality, byte lanes and replicated store data.
  always_comb begin
    illegal   = (fun3_mem == 3'b011) || (fun3_mem[2:1] == 2'b11) ||
                (mem_write_mem && fun3_mem[2]);
    unaligned = ((fun3_mem[1:0] == 2'b01) && addr_mem[0]) ||
                ((fun3_mem[1:0] == 2'b10) && (addr_mem[1:0] != 2'b00));
    access_bad = illegal | unaligned;
    sel_c = 4'b1111;
    dat_c = wdata_mem;
    case (fun3_mem[1:0])
      2'b00: begin
        sel_c = 4'b0001 << addr_mem[1:0];
        dat_c = {4{wdata_mem[7:0]}};
      end
      2'b01: begin
        sel_c = addr_mem[1] ? 4'b1100 : 4'b0011;
        dat_c = {2{wdata_mem[15:0]}};
      end
      default: begin
        sel_c = 4'b1111;
        dat_c = wdata_mem;
      end
    endcase
    if (!mem_write_mem) dat_c = '0;
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_BUS) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      fun3_q  <= '0;
      rdat_q  <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          mis_q <= 1'b0;
          err_q <= 1'b0;
          cnt_q <= '0;
          if (req) begin
            if (access_bad) begin
              mis_q <= 1'b1;
            end else begin
              adr_q  <= ADDR_W'(addr_mem);
              we_q   <= mem_write_mem;
              sel_q  <= sel_c;
              dat_q  <= dat_c;
              fun3_q <= fun3_mem;
            end
          end
        end
        S_BUS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // err outranks a simultaneous ack
          if (wb_err_i || (timeout_hit && !wb_ack_i)) begin
            err_q <= 1'b1;
          end else if (wb_ack_i) begin
            rdat_q <= wb_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    stall_pipl = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_pipl = req;
        if (req) state_d = access_bad ? S_DONE : S_BUS;
      end
      S_BUS: begin
        stall_pipl = 1'b1;
        if (wb_ack_i || wb_err_i || timeout_hit) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_cyc_o   = (state_q == S_BUS);
  assign wb_stb_o   = (state_q == S_BUS);
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign misaligned = (state_q == S_DONE) && mis_q;
  assign bus_err    = (state_q == S_DONE) && err_q;

  assign lane = rdat_q >> {adr_q[1:0], 3'b000};

  always_comb begin
    rdata_mem = '0;
    if ((state_q == S_DONE) && !mis_q && !err_q && !we_q) begin
      case (fun3_q)
        3'b000:  rdata_mem = {{24{lane[7]}}, lane[7:0]};
        3'b100:  rdata_mem = {24'd0, lane[7:0]};
        3'b001:  rdata_mem = {{16{lane[15]}}, lane[15:0]};
        3'b101:  rdata_mem = {16'd0, lane[15:0]};
        default: rdata_mem = rdat_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wb_master.sv
// tb/tb_dmem_wb_master.sv - self-checking bench for dmem_wb_master
// Directed plus randomized accesses against an arithmetic reference model.
module tb_dmem_wb_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_mem, mem_write_mem;
  logic [2:0]  fun3_mem;
  logic [31:0] addr_mem, wdata_mem;
  logic [31:0] rdata_mem;
  logic        stall_pipl, misaligned, bus_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_wb_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .fun3_mem(fun3_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .rdata_mem(rdata_mem), .stall_pipl(stall_pipl),
    .misaligned(misaligned), .bus_err(bus_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: sizes in bytes, lanes by modulo arithmetic, sign extension by subtraction.
  task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] bus,
                       output bit bad, output logic [3:0] sel,
                       output logic [31:0] dat, output logic [31:0] ld);
    int sz, off;
    logic [63:0] v;
    sz  = 1 << f3[1:0];
    off = a % 4;
    bad = (f3 == 3) || (f3 == 6) || (f3 == 7) || (wr && f3[2]) || ((a % sz) != 0);
    sel = '0; dat = '0; ld = '0;
    if (!bad) begin
      sel = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) dat[8*i +: 8] = wr ? wd[8*(i % sz) +: 8] : 8'h00;
      v = (64'(bus) >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
      if (!f3[2] && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
      ld = v[31:0];
    end
  endtask

  // Called #1 after a posedge with the DUT in IDLE; returns likewise.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] bus, input int ack_at, input int err_at);
    bit bad, fin, eerr;
    logic [3:0] esel;
    logic [31:0] edat, eld;
    model(wr, f3, a, wd, bus, bad, esel, edat, eld);
    mem_read_mem = rd; mem_write_mem = wr; fun3_mem = f3; addr_mem = a; wdata_mem = wd;
    @(negedge clk);
    chk("idle_stall", stall_pipl, 1);
    chk("idle_cyc", wb_cyc_o, 0);
    @(posedge clk); #1;
    if (bad) begin
      @(negedge clk);
      chk("bad_misaligned", misaligned, 1);
      chk("bad_stall", stall_pipl, 0);
      chk("bad_cyc", wb_cyc_o, 0);
      chk("bad_bus_err", bus_err, 0);
      chk("bad_rdata", rdata_mem, 0);
    end else begin
      fin = 0; eerr = 0;
      for (int k = 0; k < 8 && !fin; k++) begin
        wb_ack_i = (k == ack_at);
        wb_err_i = (k == err_at);
        wb_dat_i = (k == ack_at) ? bus : $urandom;
        @(negedge clk);
        chk("bus_cyc", wb_cyc_o, 1);
        chk("bus_stb", wb_stb_o, 1);
        chk("bus_stall", stall_pipl, 1);
        chk("bus_we", wb_we_o, wr);
        chk("bus_sel", wb_sel_o, esel);
        chk("bus_adr", wb_adr_o, a);
        chk("bus_dat", wb_dat_o, edat);
        if (k == ack_at || k == err_at || k == TO - 1) begin
          fin  = 1;
          eerr = (k == err_at) || (k != ack_at);
        end
        @(posedge clk); #1;
        wb_ack_i = 0; wb_err_i = 0;
      end
      @(negedge clk);
      chk("done_cyc", wb_cyc_o, 0);
      chk("done_stb", wb_stb_o, 0);
      chk("done_stall", stall_pipl, 0);
      chk("done_bus_err", bus_err, eerr);
      chk("done_misaligned", misaligned, 0);
      if (!wr) chk("done_rdata", rdata_mem, eerr ? 32'h0 : eld);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    mem_read_mem = 0; mem_write_mem = 0;
    @(negedge clk);
    chk("quiet_stall", stall_pipl, 0);
    chk("quiet_cyc", wb_cyc_o, 0);
    chk("quiet_bus_err", bus_err, 0);
    chk("quiet_rdata", rdata_mem, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    int mode;
    reset = 1; mem_read_mem = 0; mem_write_mem = 0; fun3_mem = 0;
    addr_mem = 0; wdata_mem = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_stall", stall_pipl, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_rdata", rdata_mem, 0);
    @(posedge clk); #1;
    reset = 0;

    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, -1);
    access(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 0, -1);
    access(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 0, -1);
    access(1, 0, 3'b101, 32'h102, 0, 32'h80112233, 1, -1);
    access(0, 1, 3'b000, 32'h201, 32'h000000A5, 0, 0, -1);
    access(0, 1, 3'b001, 32'h202, 32'h00001234, 0, 2, -1);
    access(1, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 0, -1);
    idle();
    access(1, 0, 3'b010, 32'h101, 0, 0, 0, -1);
    access(1, 0, 3'b011, 32'h100, 0, 0, 0, -1);
    access(0, 1, 3'b100, 32'h100, 32'h55, 0, 0, -1);
    access(1, 0, 3'b001, 32'h103, 0, 0, 0, -1);
    idle();
    access(1, 0, 3'b010, 32'h300, 0, 32'h12345678, -1, -1);
    wb_ack_i = 1;
    idle();
    wb_ack_i = 0;
    access(1, 0, 3'b010, 32'h304, 0, 32'h12345678, -1, 1);
    access(1, 0, 3'b010, 32'h308, 0, 32'h12345678, 0, 0);
    idle();

    mem_read_mem = 1; fun3_mem = 3'b010; addr_mem = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_cyc", wb_cyc_o, 1);
    reset = 1; mem_read_mem = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_cyc", wb_cyc_o, 0);
    chk("midrst_stb", wb_stb_o, 0);
    chk("midrst_stall", stall_pipl, 0);
    @(posedge clk); #1;
    reset = 0;
    idle();

    for (int n = 0; n < 60; n++) begin
      bit rd, wr;
      int ack_at, err_at;
      mode = $urandom_range(0, 2);
      rd = (mode != 1);
      wr = (mode != 0);
      r = $urandom;
      ack_at = $urandom_range(0, 2);
      err_at = -1;
      mode = $urandom_range(0, 5);
      if (mode == 4) err_at = $urandom_range(0, 2);
      if (mode == 5) ack_at = -1;
      access(rd, wr, 3'($urandom_range(0, 7)), {20'h00010, r[11:0]}, $urandom, $urandom,
             ack_at, err_at);
      if (r[31]) idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
